// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants: receiver FSM states, frame geometry and
// the scan-code prefixes that downstream software decodes.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int unsigned FRAME_BITS = 11;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous byte FIFO with registered head/empty outputs and a sticky
// overflow flag; a simultaneous push and pop is always accepted.
module ps2_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       empty,
    output logic       full,
    output logic       overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] wr_next;
    logic [AW:0] rd_next;
    logic        is_empty;
    logic        do_push;
    logic        do_pop;
    logic [7:0]  head_next;

    assign is_empty = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Head is registered from next-state, so a byte being written this cycle
    // must bypass the memory when it becomes the new head.
    always_comb begin
        do_pop    = pop && !is_empty;
        do_push   = push && (!full || do_pop);
        wr_next   = do_push ? wr_ptr + 1'b1 : wr_ptr;
        rd_next   = do_pop  ? rd_ptr + 1'b1 : rd_ptr;
        head_next = '0;
        if (wr_next != rd_next) begin
            if (do_push && (rd_next[AW-1:0] == wr_ptr[AW-1:0]))
                head_next = din;
            else
                head_next = mem[rd_next[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            head     <= '0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            head   <= head_next;
            empty  <= (wr_next == rd_next);
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronises the pad signals, deframes 11-bit
// frames with parity/stop checking and queues raw scan-code bytes.
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       key_ack,
    output logic [7:0] key_code,
    output logic       key_ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic          fall;
    logic          data_s;

    ps2_state_t    state;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic [TW-1:0] tmo;
    logic          push_q;
    logic [7:0]    byte_q;
    logic          fifo_empty;
    logic          fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign data_s = data_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            tmo        <= '0;
            push_q     <= 1'b0;
            byte_q     <= '0;
            frame_err  <= 1'b0;
        end else begin
            push_q    <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                tmo <= '0;
                unique case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_s, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        parity_bit <= data_s;
                        state      <= STOP;
                    end
                    STOP: begin
                        byte_q <= shreg;
                        if (data_s && (^{shreg, parity_bit}))
                            push_q <= 1'b1;
                        else
                            frame_err <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // Abandon a stalled partial frame so the next start bit resynchronises.
                if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    state <= IDLE;
                    tmo   <= '0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end
        end
    end

    ps2_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_q),
        .pop     (key_ack),
        .din     (byte_q),
        .head    (key_code),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .overflow(overflow)
    );

    assign key_ready = ~fifo_empty;

endmodule
